// File: rtl/simple_axi_to_axi_read.sv
// Simple-bus read request (byte address + byte length) to AXI4 INCR read bursts.
// Bursts are capped at 256 beats, never cross a 4KB boundary, and return data is passed straight through.
module simple_axi_to_axi_read #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ID_W   = 1,
  parameter int LEN_W      = 20
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m_rvalid_i,
  output logic                  m_rready_o,
  input  logic [AXI_ADDR_W-1:0] m_raddr_i,
  input  logic [LEN_W-1:0]      m_rlen_i,
  output logic [AXI_DATA_W-1:0] m_rdata_o,
  output logic                  m_rdata_valid_o,
  input  logic                  m_rdata_ready_i,
  output logic                  m_rlast_o,
  output logic                  m_rerror_o,
  output logic [AXI_ID_W-1:0]   axi_arid_o,
  output logic [AXI_ADDR_W-1:0] axi_araddr_o,
  output logic [AXI_LEN_W-1:0]  axi_arlen_o,
  output logic [2:0]            axi_arsize_o,
  output logic [1:0]            axi_arburst_o,
  output logic [1:0]            axi_arlock_o,
  output logic [3:0]            axi_arcache_o,
  output logic [2:0]            axi_arprot_o,
  output logic [3:0]            axi_arqos_o,
  output logic                  axi_arvalid_o,
  input  logic                  axi_arready_i,
  input  logic [AXI_ID_W-1:0]   axi_rid_i,
  input  logic [AXI_DATA_W-1:0] axi_rdata_i,
  input  logic [1:0]            axi_rresp_i,
  input  logic                  axi_rlast_i,
  input  logic                  axi_rvalid_i,
  output logic                  axi_rready_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      remaining_q, remaining_d;
  logic [AXI_LEN_W-1:0]  arlen_q, arlen_d;
  logic [LEN_W-1:0]      bytes_q, bytes_d;
  logic                  final_burst_q, final_burst_d;
  logic                  arvalid_q, arvalid_d;
  logic                  m_rready_q, m_rready_d;
  logic                  rerror_q, rerror_d;

  logic                  in_data_s;
  logic                  beat_fire_s;
  logic [LEN_W:0]        words_s;
  logic [12:0]           room_s;
  logic [LEN_W:0]        beats_s;
  logic [LEN_W:0]        beat_bytes_s;
  logic                  unused_ok_s;

  // Responses are routed by the interconnect; the returned ID carries no information here.
  assign unused_ok_s = ^axi_rid_i;

  assign axi_arid_o    = {AXI_ID_W{1'b0}};
  assign axi_arsize_o  = 3'b010;
  assign axi_arburst_o = 2'b01;
  assign axi_arlock_o  = 2'b00;
  assign axi_arcache_o = 4'b0000;
  assign axi_arprot_o  = 3'b000;
  assign axi_arqos_o   = 4'b0000;
  assign axi_araddr_o  = addr_q;
  assign axi_arlen_o   = arlen_q;
  assign axi_arvalid_o = arvalid_q;
  assign m_rready_o    = m_rready_q;
  assign m_rerror_o    = rerror_q;

  // R channel is a zero-latency pass-through, only open while a burst is being drained.
  assign in_data_s       = (state_q == S_DATA);
  assign axi_rready_o    = in_data_s & m_rdata_ready_i;
  assign m_rdata_valid_o = in_data_s & axi_rvalid_i;
  assign m_rdata_o       = axi_rdata_i;
  assign m_rlast_o       = in_data_s & axi_rvalid_i & axi_rlast_i & final_burst_q;
  assign beat_fire_s     = in_data_s & axi_rvalid_i & m_rdata_ready_i;

  assign words_s      = ({1'b0, remaining_q} + (LEN_W+1)'(2'd3)) >> 2;
  assign room_s       = (13'd4096 - {1'b0, addr_q[11:0]}) >> 2;
  assign beat_bytes_s = beats_s << 2;

  // Burst size: smallest of words left, the 256-beat cap and the words left in this 4KB page.
  always_comb begin
    beats_s = (LEN_W+1)'(9'd256);
    if (words_s < beats_s) begin
      beats_s = words_s;
    end else begin
      beats_s = beats_s;
    end
    if ((LEN_W+1)'(room_s) < beats_s) begin
      beats_s = (LEN_W+1)'(room_s);
    end else begin
      beats_s = beats_s;
    end
  end

  // Next-state and register-update logic for the request/burst sequencer.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    arlen_d       = arlen_q;
    bytes_d       = bytes_q;
    final_burst_d = final_burst_q;
    arvalid_d     = arvalid_q;
    m_rready_d    = 1'b0;
    rerror_d      = rerror_q;
    case (state_q)
      S_IDLE: begin
        // m_rready_q guards against re-latching a zero-length request still held for one cycle.
        if (m_rvalid_i && !m_rready_q) begin
          m_rready_d  = 1'b1;
          addr_d      = m_raddr_i & ~AXI_ADDR_W'(2'b11);
          remaining_d = m_rlen_i;
          rerror_d    = 1'b0;
          if (m_rlen_i == {LEN_W{1'b0}}) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        arlen_d = AXI_LEN_W'(beats_s - (LEN_W+1)'(1'b1));
        if (beat_bytes_s < {1'b0, remaining_q}) begin
          bytes_d = LEN_W'(beat_bytes_s);
        end else begin
          bytes_d = remaining_q;
        end
        final_burst_d = (beat_bytes_s >= {1'b0, remaining_q});
        arvalid_d     = 1'b1;
        state_d       = S_ADDR;
      end
      S_ADDR: begin
        if (axi_arready_i) begin
          arvalid_d   = 1'b0;
          addr_d      = addr_q + ((AXI_ADDR_W'(arlen_q) + AXI_ADDR_W'(1'b1)) << 2'd2);
          remaining_d = remaining_q - bytes_q;
          state_d     = S_DATA;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_DATA: begin
        if (beat_fire_s) begin
          if (axi_rresp_i != 2'b00) begin
            rerror_d = 1'b1;
          end else begin
            rerror_d = rerror_q;
          end
          if (axi_rlast_i) begin
            state_d = S_GAP;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_GAP: begin
        if (remaining_q == {LEN_W{1'b0}}) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_CALC;
        end
      end
      default: begin
        state_d   = S_IDLE;
        arvalid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      addr_q        <= {AXI_ADDR_W{1'b0}};
      remaining_q   <= {LEN_W{1'b0}};
      arlen_q       <= {AXI_LEN_W{1'b0}};
      bytes_q       <= {LEN_W{1'b0}};
      final_burst_q <= 1'b0;
      arvalid_q     <= 1'b0;
      m_rready_q    <= 1'b0;
      rerror_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      arlen_q       <= arlen_d;
      bytes_q       <= bytes_d;
      final_burst_q <= final_burst_d;
      arvalid_q     <= arvalid_d;
      m_rready_q    <= m_rready_d;
      rerror_q      <= rerror_d;
    end
  end

endmodule

// File: tb/tb_simple_axi_to_axi_read.sv
// Scoreboard bench for simple_axi_to_axi_read: a behavioural AXI read slave plus a
// reference burst-splitting model that queues expected AR requests and returned words.
module tb_simple_axi_to_axi_read;

  logic        clk;
  logic        rst_i;
  logic        m_rvalid, m_rready_o;
  logic [31:0] m_raddr;
  logic [19:0] m_rlen;
  logic [31:0] m_rdata_o;
  logic        m_rdata_valid_o, m_rdata_ready, m_rlast_o, m_rerror_o;
  logic [0:0]  axi_arid_o;
  logic [31:0] axi_araddr_o;
  logic [7:0]  axi_arlen_o;
  logic [2:0]  axi_arsize_o;
  logic [1:0]  axi_arburst_o, axi_arlock_o;
  logic [3:0]  axi_arcache_o, axi_arqos_o;
  logic [2:0]  axi_arprot_o;
  logic        axi_arvalid_o, axi_arready;
  logic [0:0]  axi_rid;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast, axi_rvalid, axi_rready_o;

  simple_axi_to_axi_read dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_rvalid_i(m_rvalid), .m_rready_o(m_rready_o), .m_raddr_i(m_raddr), .m_rlen_i(m_rlen),
    .m_rdata_o(m_rdata_o), .m_rdata_valid_o(m_rdata_valid_o), .m_rdata_ready_i(m_rdata_ready),
    .m_rlast_o(m_rlast_o), .m_rerror_o(m_rerror_o),
    .axi_arid_o(axi_arid_o), .axi_araddr_o(axi_araddr_o), .axi_arlen_o(axi_arlen_o),
    .axi_arsize_o(axi_arsize_o), .axi_arburst_o(axi_arburst_o), .axi_arlock_o(axi_arlock_o),
    .axi_arcache_o(axi_arcache_o), .axi_arprot_o(axi_arprot_o), .axi_arqos_o(axi_arqos_o),
    .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready),
    .axi_rid_i(axi_rid), .axi_rdata_i(axi_rdata), .axi_rresp_i(axi_rresp),
    .axi_rlast_i(axi_rlast), .axi_rvalid_i(axi_rvalid), .axi_rready_o(axi_rready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct packed { logic [31:0] data; logic last; } w_t;

  ar_t exp_ar_q[$];
  ar_t burst_q[$];
  w_t  exp_w_q[$];

  int   n_total = 0;
  int   n_bad = 0;
  int   ready_mode = 0;
  int   err_word = -1;
  int   slave_word = 0;
  int   beat = 0;
  logic err_exp = 1'b0;
  logic ar_fire = 1'b0;
  logic r_fire = 1'b0;
  logic seen_arvalid = 1'b0;
  ar_t  cap_ar;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Reference split: 256-beat cap, 4KB boundary, final word flagged on the last burst.
  task automatic push_model(input logic [31:0] addr_in, input int len);
    logic [31:0] a;
    int rem, beats, room, nbytes;
    a = addr_in & 32'hFFFF_FFFC;
    rem = len;
    while (rem > 0) begin
      beats = (rem + 3) / 4;
      if (beats > 256) beats = 256;
      room = (4096 - int'(a[11:0])) / 4;
      if (room < beats) beats = room;
      exp_ar_q.push_back('{a, 8'(beats - 1)});
      for (int k = 0; k < beats; k++)
        exp_w_q.push_back('{mem_word(a + 32'(4 * k)), (beats * 4 >= rem) && (k == beats - 1)});
      nbytes = (beats * 4 < rem) ? beats * 4 : rem;
      a = a + 32'(beats * 4);
      rem = rem - nbytes;
    end
  endtask

  task automatic do_req(input logic [31:0] addr, input int len);
    logic got;
    slave_word = 0;
    push_model(addr, len);
    @(posedge clk); #1;
    m_rvalid = 1'b1;
    m_raddr = addr;
    m_rlen = 20'(len);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (m_rready_o) got = 1'b1;
    end
    m_rvalid = 1'b0;
    check_eq("req_ack", got, 1);
    check_eq("err_clear", m_rerror_o, 0);
    err_exp = 1'b0;
    @(negedge clk);
    check_eq("ack_pulse", m_rready_o, 0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 4000; i++) begin
      if (exp_w_q.size() == 0 && exp_ar_q.size() == 0) break;
      @(negedge clk);
    end
    check_eq("words_left", exp_w_q.size(), 0);
    check_eq("ars_left", exp_ar_q.size(), 0);
    repeat (4) @(negedge clk);
    check_eq("bursts_left", burst_q.size(), 0);
  endtask

  // AXI slave and requester-side monitor: drive #1 after posedge, sample on negedge.
  initial begin
    w_t  w;
    logic fire_m;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = 32'h0; axi_rlast = 1'b0;
    axi_rresp = 2'b00; axi_rid = 1'b0; m_rdata_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rst_i) begin
        axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0; beat = 0;
        burst_q.delete();
      end else begin
        if (ar_fire) begin
          check_eq("ar_overlap", burst_q.size(), 0);
          if (exp_ar_q.size() == 0) begin
            check_eq("ar_unexpected", exp_ar_q.size(), 1);
          end else begin
            ar_t e;
            e = exp_ar_q.pop_front();
            check_eq("araddr", cap_ar.addr, e.addr);
            check_eq("arlen", {24'h0, cap_ar.len}, {24'h0, e.len});
          end
          burst_q.push_back(cap_ar);
        end
        if (r_fire) begin
          slave_word++;
          if (axi_rlast) begin
            void'(burst_q.pop_front());
            beat = 0;
          end else begin
            beat++;
          end
        end
        axi_arready = axi_arvalid_o && ($urandom_range(0, 2) != 0);
        if (burst_q.size() > 0) begin
          if (!(axi_rvalid && !r_fire)) axi_rvalid = ($urandom_range(0, 3) != 0);
          axi_rdata = mem_word(burst_q[0].addr + 32'(4 * beat));
          axi_rlast = (beat == int'(burst_q[0].len));
          axi_rresp = (slave_word == err_word) ? 2'b10 : 2'b00;
        end else begin
          axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rresp = 2'b00;
        end
      end
      case (ready_mode)
        0: m_rdata_ready = 1'b1;
        1: m_rdata_ready = ~m_rdata_ready;
        default: m_rdata_ready = ($urandom_range(0, 1) == 1);
      endcase
      @(negedge clk);
      ar_fire = axi_arvalid_o && axi_arready;
      if (ar_fire) begin
        cap_ar = '{axi_araddr_o, axi_arlen_o};
        check_eq("arsize", axi_arsize_o, 3'b010);
        check_eq("arburst", axi_arburst_o, 2'b01);
        check_eq("ar_zero_fields", {axi_arid_o, axi_arlock_o, axi_arcache_o, axi_arprot_o, axi_arqos_o}, 0);
      end
      if (axi_arvalid_o) seen_arvalid = 1'b1;
      r_fire = axi_rvalid && axi_rready_o;
      fire_m = m_rdata_valid_o && m_rdata_ready;
      if (m_rdata_valid_o) check_eq("rready_mirror", axi_rready_o, m_rdata_ready);
      if (fire_m || r_fire) begin
        check_eq("r_handshake", r_fire, fire_m);
        if (exp_w_q.size() == 0) begin
          check_eq("word_unexpected", exp_w_q.size(), 1);
        end else begin
          w = exp_w_q.pop_front();
          check_eq("rdata", m_rdata_o, w.data);
          check_eq("rlast", m_rlast_o, w.last);
        end
        check_eq("rerror", m_rerror_o, err_exp);
        if (axi_rresp != 2'b00) err_exp = 1'b1;
      end
    end
  end

  initial begin
    rst_i = 1'b1; m_rvalid = 1'b0; m_raddr = 32'h0; m_rlen = 20'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_arvalid", axi_arvalid_o, 0);
    check_eq("rst_m_rready", m_rready_o, 0);
    check_eq("rst_rerror", m_rerror_o, 0);
    check_eq("rst_araddr", axi_araddr_o, 0);
    check_eq("rst_arlen", axi_arlen_o, 0);
    check_eq("rst_rdata_valid", m_rdata_valid_o, 0);
    check_eq("rst_rready", axi_rready_o, 0);
    #2 rst_i = 1'b0;

    do_req(32'h100, 16);   wait_done();
    ready_mode = 2;
    do_req(32'h0, 1030);   wait_done();
    do_req(32'hFF8, 16);   wait_done();
    ready_mode = 1;
    do_req(32'h2004, 10);  wait_done();
    ready_mode = 0;
    err_word = 1;
    do_req(32'h300, 16);   wait_done();
    check_eq("err_sticky", m_rerror_o, 1);
    err_word = -1;

    seen_arvalid = 1'b0;
    do_req(32'h40, 0);
    repeat (10) @(negedge clk);
    check_eq("len0_no_ar", seen_arvalid, 0);

    // Reset while a burst is being drained.
    do_req(32'h500, 64);
    for (int i = 0; i < 500; i++) begin
      if (exp_w_q.size() <= 12) break;
      @(negedge clk);
    end
    check_eq("mid_burst_reached", exp_w_q.size() <= 12, 1);
    #2 rst_i = 1'b1;
    exp_w_q.delete(); exp_ar_q.delete();
    ar_fire = 1'b0; r_fire = 1'b0;
    @(negedge clk);
    check_eq("mrst_arvalid", axi_arvalid_o, 0);
    check_eq("mrst_rready", axi_rready_o, 0);
    check_eq("mrst_rdata_valid", m_rdata_valid_o, 0);
    check_eq("mrst_m_rready", m_rready_o, 0);
    #2 rst_i = 1'b0;
    do_req(32'h600, 8);    wait_done();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
